uart_tx_serializer: RTL and testbench



---
 rtl/uart_tx_serializer.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer fed by the TX FIFO: start bit, DBIT data bits LSB first, optional parity, stop.
// Define UART_TX_TWO_STOP_EN to add the stop2 input selecting a two-bit-period stop.

module uart_tx_serializer #(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic            apb_pclk,
  input  logic            apb_prstn,
  input  logic            b_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] d_in,
  input  logic            parity_en,
`ifdef UART_TX_TWO_STOP_EN
  input  logic            stop2,
`endif
  output logic            tx_done,
  output logic            tx,
  output logic            busy
);

  localparam int unsigned   TW        = (SB_TICK > 1) ? $clog2(SB_TICK) : 1;
  localparam int unsigned   BW        = $clog2(DBIT);
  localparam logic [TW-1:0] TICK_LAST = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DBIT - 1);
  localparam logic          ODD_BIT   = 1'(PARITY_ODD);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t          state;
  logic [TW-1:0]   tick_cnt;
  logic [BW-1:0]   bit_idx;
  logic [DBIT-1:0] shift;
  logic            par_en_q;
  logic            par_bit_q;
  logic            tick_end_c;
  logic            stop_end_c;

  assign tick_end_c = b_tick && (tick_cnt == TICK_LAST);

`ifdef UART_TX_TWO_STOP_EN
  logic stop2_q;
  logic stop_phase;
  // With two stop bits the tick counter wraps once; stop_phase marks the second period.
  assign stop_end_c = tick_end_c && (!stop2_q || stop_phase);
`else
  assign stop_end_c = tick_end_c;
`endif

  // Frame sequencer; tx, tx_done and busy are all driven from registers.
  always_ff @(posedge apb_pclk or negedge apb_prstn) begin
    if (!apb_prstn) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx        <= 1'b1;
      tx_done   <= 1'b0;
      busy      <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop2_q    <= 1'b0;
      stop_phase <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx      <= 1'b1;
          tx_done <= 1'b0;
          if (tx_start) begin
            shift     <= d_in;
            par_en_q  <= parity_en;
            par_bit_q <= (^d_in) ^ ODD_BIT;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            tx        <= 1'b0;
            busy      <= 1'b1;
            state     <= START;
`ifdef UART_TX_TWO_STOP_EN
            stop2_q    <= stop2;
            stop_phase <= 1'b0;
`endif
          end
        end

        START: begin
          if (tick_end_c) begin
            tick_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shift[0];
            state    <= DATA;
          end else if (b_tick) begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end

        DATA: begin
          if (tick_end_c) begin
            tick_cnt <= '0;
            shift    <= shift >> 1;
            if (bit_idx == BIT_LAST) begin
              if (par_en_q) begin
                tx    <= par_bit_q;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_idx <= bit_idx + BW'(1);
              tx      <= shift[1];
            end
          end else if (b_tick) begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end

        PARITY: begin
          if (tick_end_c) begin
            tick_cnt <= '0;
            tx       <= 1'b1;
            state    <= STOP;
          end else if (b_tick) begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end

        STOP: begin
          // Stay in STOP through the tx_done cycle so tx_start is next seen after the FIFO pop.
          if (tx_done) begin
            tx_done <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else if (stop_end_c) begin
            tick_cnt <= '0;
            tx_done  <= 1'b1;
`ifdef UART_TX_TWO_STOP_EN
          end else if (tick_end_c) begin
            tick_cnt   <= '0;
            stop_phase <= 1'b1;
`endif
          end else if (b_tick) begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end

        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: frame contents, bit timing, parity, FIFO handshake, reset abort.
// Build with UART_TX_TWO_STOP_EN defined to also exercise the two-stop-bit frame.

module tb_uart_tx_serializer;

  logic       apb_pclk;
  logic       apb_prstn;
  logic       b_tick;
  logic       tx_start;
  logic [7:0] d_in;
  logic       parity_en;
`ifdef UART_TX_TWO_STOP_EN
  logic       stop2;
`endif
  logic       tx_done, tx, busy;
  logic       tx_done_odd, tx_odd, busy_odd;

  int n_cmp;
  int n_fail;
  int cyc;
  int tcnt;

  // Results of the most recent capture_frame call.
  logic [15:0] cap_bits;
  logic [15:0] cap_bits_odd;
  int          cap_done_cnt;
  int          cap_done_tick;
  int          cap_t_fall;
  int          cap_t_done;
  int          cap_edges[$];

  logic       fifo_run;
  logic [7:0] fq[$];

  uart_tx_serializer #(.DBIT(8), .SB_TICK(16), .PARITY_ODD(0)) dut (
    .apb_pclk (apb_pclk),
    .apb_prstn(apb_prstn),
    .b_tick   (b_tick),
    .tx_start (tx_start),
    .d_in     (d_in),
    .parity_en(parity_en),
`ifdef UART_TX_TWO_STOP_EN
    .stop2    (stop2),
`endif
    .tx_done  (tx_done),
    .tx       (tx),
    .busy     (busy)
  );

  uart_tx_serializer #(.DBIT(8), .SB_TICK(16), .PARITY_ODD(1)) dut_odd (
    .apb_pclk (apb_pclk),
    .apb_prstn(apb_prstn),
    .b_tick   (b_tick),
    .tx_start (tx_start),
    .d_in     (d_in),
    .parity_en(parity_en),
`ifdef UART_TX_TWO_STOP_EN
    .stop2    (stop2),
`endif
    .tx_done  (tx_done_odd),
    .tx       (tx_odd),
    .busy     (busy_odd)
  );

  initial begin
    apb_pclk = 1'b0;
    forever #5 apb_pclk = ~apb_pclk;
  end

  // Baud tick: one clock high in every four, changed just after the rising edge.
  initial begin
    cyc    = 0;
    tcnt   = 0;
    b_tick = 1'b0;
    forever begin
      @(posedge apb_pclk);
      cyc++;
      #1;
      tcnt   = (tcnt + 1) % 4;
      b_tick = (tcnt == 3);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach the end of the test sequence");
    $fatal(1);
  end

  // Follow one frame from the falling start edge to tx_done, sampling each bit at mid-period (tick 8 of 16).
  task automatic capture_frame(input int nbits);
    int   c;
    int   guard;
    logic prev;
    cap_bits      = '0;
    cap_bits_odd  = '0;
    cap_done_cnt  = 0;
    cap_done_tick = -1;
    cap_t_fall    = -1;
    cap_t_done    = -1;
    cap_edges.delete();
    guard = 0;
    while (tx !== 1'b0 && guard < 300) begin
      @(negedge apb_pclk);
      guard++;
    end
    if (tx !== 1'b0) return;
    cap_t_fall = cyc;
    prev  = 1'b0;
    c     = 0;
    guard = 0;
    while (cap_done_cnt == 0 && guard < nbits * 64 + 400) begin
      if (tx !== prev) begin
        cap_edges.push_back(cyc);
        prev = tx;
      end
      if (tx_done === 1'b1) begin
        cap_done_cnt  = 1;
        cap_done_tick = c;
        cap_t_done    = cyc;
      end else begin
        if (b_tick === 1'b1) begin
          if ((c % 16) == 8 && (c / 16) < 16) begin
            cap_bits[4'(c / 16)]     = tx;
            cap_bits_odd[4'(c / 16)] = tx_odd;
          end
          c++;
        end
        @(negedge apb_pclk);
        guard++;
      end
    end
  endtask

  task automatic test_reset();
    apb_prstn = 1'b0;
    repeat (3) @(negedge apb_pclk);
    n_cmp++;
    if ({tx, tx_done, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_outputs: {tx,tx_done,busy}=%b required 100", {tx, tx_done, busy});
    end
    apb_prstn = 1'b1;
    repeat (5) @(negedge apb_pclk);
    n_cmp++;
    if ({tx, tx_done, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL idle_after_reset: {tx,tx_done,busy}=%b required 100", {tx, tx_done, busy});
    end
  endtask

  task automatic test_basic();
    int bad;
    int extra;
    int stop_len;
    @(negedge apb_pclk);
    d_in      = 8'h55;
    parity_en = 1'b0;
    tx_start  = 1'b1;
    @(negedge apb_pclk);
    n_cmp++;
    if ({tx, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL start_latency: {tx,busy}=%b required 01", {tx, busy});
    end
    // Drop the request and disturb the inputs; the latched byte and parity enable must be used.
    tx_start  = 1'b0;
    d_in      = 8'hFF;
    parity_en = 1'b1;
    capture_frame(10);
    n_cmp++;
    if (cap_bits[9:0] !== 10'h2AA) begin
      n_fail++;
      $display("FAIL frame_55: bits=%h required 2aa", cap_bits[9:0]);
    end
    n_cmp++;
    if (cap_done_tick !== 160) begin
      n_fail++;
      $display("FAIL frame_55_ticks: tx_done after %0d ticks required 160", cap_done_tick);
    end
    bad = 0;
    for (int i = 1; i < cap_edges.size(); i++)
      if (cap_edges[i] - cap_edges[i-1] != 64) bad++;
    n_cmp++;
    if (cap_edges.size() != 9 || bad != 0) begin
      n_fail++;
      $display("FAIL bit_period_55: %0d edges with %0d off-period gaps, required 9 edges 64 clocks apart",
               cap_edges.size(), bad);
    end
    stop_len = (cap_edges.size() > 0) ? cap_t_done - cap_edges[cap_edges.size()-1] : -1;
    n_cmp++;
    if (stop_len != 64) begin
      n_fail++;
      $display("FAIL stop_len_55: %0d clocks required 64", stop_len);
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_at_done: busy=%b required 1", busy);
    end
    @(negedge apb_pclk);
    n_cmp++;
    if ({tx, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL after_frame_55: {tx,busy}=%b required 10", {tx, busy});
    end
    extra = 0;
    repeat (100) begin
      @(negedge apb_pclk);
      if (tx_done === 1'b1 || tx !== 1'b1) extra++;
    end
    n_cmp++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL idle_after_55: %0d cycles with activity required 0", extra);
    end
    parity_en = 1'b0;
  endtask

  task automatic test_parity_even();
    @(negedge apb_pclk);
    d_in      = 8'h07;
    parity_en = 1'b1;
    tx_start  = 1'b1;
    @(negedge apb_pclk);
    tx_start  = 1'b0;
    capture_frame(11);
    n_cmp++;
    if (cap_bits[10:0] !== 11'h60E) begin
      n_fail++;
      $display("FAIL frame_07_par: bits=%h required 60e", cap_bits[10:0]);
    end
    n_cmp++;
    if (cap_done_tick !== 176) begin
      n_fail++;
      $display("FAIL frame_07_len: tx_done after %0d ticks required 176", cap_done_tick);
    end
    repeat (20) @(negedge apb_pclk);
  endtask

  task automatic test_parity_zero();
    @(negedge apb_pclk);
    d_in      = 8'h00;
    parity_en = 1'b1;
    tx_start  = 1'b1;
    @(negedge apb_pclk);
    tx_start  = 1'b0;
    capture_frame(11);
    n_cmp++;
    if (cap_bits[10:0] !== 11'h400) begin
      n_fail++;
      $display("FAIL frame_00_even: bits=%h required 400", cap_bits[10:0]);
    end
    n_cmp++;
    if (cap_bits_odd[10:0] !== 11'h600) begin
      n_fail++;
      $display("FAIL frame_00_odd: bits=%h required 600", cap_bits_odd[10:0]);
    end
    repeat (3) @(negedge apb_pclk);
    n_cmp++;
    if ({busy, busy_odd} !== 2'b00) begin
      n_fail++;
      $display("FAIL busy_after_parity: {busy,busy_odd}=%b required 00", {busy, busy_odd});
    end
    parity_en = 1'b0;
    repeat (20) @(negedge apb_pclk);
  endtask

  task automatic test_fifo_back_to_back();
    logic [9:0] b1;
    int         t_done1;
    int         d1;
    int         gap;
    int         extra_done;
    int         extra_fall;
    logic       pop_pending;
    logic [7:0] tmp;
    fq.delete();
    fq.push_back(8'hA5);
    fq.push_back(8'h3C);
    parity_en  = 1'b0;
    fifo_run   = 1'b1;
    extra_done = 0;
    extra_fall = 0;
    b1         = '0;
    t_done1    = -1;
    d1         = 0;
    gap        = -1;
    @(negedge apb_pclk);
    fork
      begin
        // FIFO model: pops on the edge that ends the tx_done cycle; tx_start is its not-empty flag.
        pop_pending = 1'b0;
        while (fifo_run) begin
          if (pop_pending && fq.size() != 0) tmp = fq.pop_front();
          pop_pending = (tx_done === 1'b1);
          tx_start    = (fq.size() != 0);
          d_in        = (fq.size() != 0) ? fq[0] : 8'h00;
          @(negedge apb_pclk);
        end
        tx_start = 1'b0;
      end
      begin
        capture_frame(10);
        b1      = cap_bits[9:0];
        t_done1 = cap_t_done;
        d1      = cap_done_cnt;
        capture_frame(10);
        gap = cap_t_fall - t_done1;
        repeat (300) begin
          @(negedge apb_pclk);
          if (tx_done === 1'b1) extra_done++;
          if (tx !== 1'b1) extra_fall++;
        end
        fifo_run = 1'b0;
      end
    join
    n_cmp++;
    if (b1 !== 10'h34A) begin
      n_fail++;
      $display("FAIL fifo_frame1: bits=%h required 34a", b1);
    end
    n_cmp++;
    if (cap_bits[9:0] !== 10'h278) begin
      n_fail++;
      $display("FAIL fifo_frame2: bits=%h required 278", cap_bits[9:0]);
    end
    n_cmp++;
    if (gap != 2) begin
      n_fail++;
      $display("FAIL fifo_gap: next start bit %0d clocks after tx_done, required 2", gap);
    end
    n_cmp++;
    if (d1 + cap_done_cnt + extra_done != 2 || extra_fall != 0) begin
      n_fail++;
      $display("FAIL fifo_pulses: %0d tx_done pulses, %0d stray low cycles, required 2 and 0",
               d1 + cap_done_cnt + extra_done, extra_fall);
    end
    n_cmp++;
    if (fq.size() != 0) begin
      n_fail++;
      $display("FAIL fifo_drained: %0d entries left required 0", fq.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    int c;
    int guard;
    int bad;
    @(negedge apb_pclk);
    d_in      = 8'h00;
    parity_en = 1'b0;
    tx_start  = 1'b1;
    @(negedge apb_pclk);
    tx_start  = 1'b0;
    c     = 0;
    guard = 0;
    while (c < 72 && guard < 1000) begin
      if (b_tick === 1'b1) c++;
      @(negedge apb_pclk);
      guard++;
    end
    n_cmp++;
    if (c != 72 || tx !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_abort: ticks=%0d tx=%b busy=%b required 72 0 1", c, tx, busy);
    end
    #2;
    apb_prstn = 1'b0;
    #1;
    n_cmp++;
    if ({tx, tx_done, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL async_abort: {tx,tx_done,busy}=%b required 100", {tx, tx_done, busy});
    end
    bad = 0;
    repeat (3) begin
      @(negedge apb_pclk);
      if (tx_done === 1'b1 || tx !== 1'b1) bad++;
    end
    apb_prstn = 1'b1;
    repeat (200) begin
      @(negedge apb_pclk);
      if (tx_done === 1'b1 || tx !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL idle_after_abort: %0d cycles with activity required 0", bad);
    end
    tx_start = 1'b1;
    @(negedge apb_pclk);
    tx_start = 1'b0;
    n_cmp++;
    if (tx !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_latency: tx=%b required 0", tx);
    end
    capture_frame(10);
    n_cmp++;
    if (cap_bits[9:0] !== 10'h200 || cap_done_tick !== 160) begin
      n_fail++;
      $display("FAIL restart_frame: bits=%h ticks=%0d required 200 and 160", cap_bits[9:0], cap_done_tick);
    end
    repeat (20) @(negedge apb_pclk);
  endtask

`ifdef UART_TX_TWO_STOP_EN
  task automatic test_two_stop();
    int high_len;
    @(negedge apb_pclk);
    d_in      = 8'hFF;
    parity_en = 1'b0;
    stop2     = 1'b1;
    tx_start  = 1'b1;
    @(negedge apb_pclk);
    tx_start  = 1'b0;
    stop2     = 1'b0;
    capture_frame(11);
    n_cmp++;
    if (cap_bits[10:0] !== 11'h7FE || cap_done_tick !== 176) begin
      n_fail++;
      $display("FAIL two_stop_frame: bits=%h ticks=%0d required 7fe and 176", cap_bits[10:0], cap_done_tick);
    end
    high_len = (cap_edges.size() == 1) ? cap_t_done - cap_edges[0] : -1;
    n_cmp++;
    if (high_len != 640) begin
      n_fail++;
      $display("FAIL two_stop_high: high level %0d clocks required 640", high_len);
    end
    repeat (20) @(negedge apb_pclk);
  endtask
`endif

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    apb_prstn = 1'b0;
    tx_start  = 1'b0;
    parity_en = 1'b0;
    d_in      = 8'h00;
    fifo_run  = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
    stop2     = 1'b0;
`endif
    test_reset();
    test_basic();
    test_parity_even();
    test_parity_zero();
    test_fifo_back_to_back();
    test_reset_mid_frame();
`ifdef UART_TX_TWO_STOP_EN
    test_two_stop();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
